switch_pre: RTL and testbench
=============================

SWITCH_PRE -- requirements
Module: switch_pre

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port data_fifo_wr, input, 1 bit: upstream byte write strobe.
REQ-004 SHALL have port data_fifo_din, input, 8 bits: frame byte, first byte first.
REQ-005 SHALL have port ptr_fifo_wr, input, 1 bit: frame descriptor write strobe.
REQ-006 SHALL have port ptr_fifo_din, input, 16 bits: [15:12] portmap, [11:0] frame length L in bytes.
REQ-007 SHALL have port bp, output, 1 bit: backpressure to upstream.
REQ-008 SHALL have port i_cell_data_fifo_wr, output, 1 bit: cell write strobe, one 128-bit cell per pulse.
REQ-009 SHALL have port i_cell_data_fifo_dout, output, 128 bits: cell data; byte k occupies [127-8k:120-8k].
REQ-010 SHALL have port i_cell_first, output, 1 bit: marks the first cell of a frame.
REQ-011 SHALL have port i_cell_last, output, 1 bit: marks the last cell of a frame.
REQ-012 SHALL have port i_cell_data_fifo_bp, input, 1 bit: downstream cell FIFO almost full.

Function
REQ-013 SHALL buffer bytes in an internal sfifo_w8_d4k (standard read, 1-cycle latency) and descriptors in an internal sfifo_w16_d32.
REQ-014 Upstream SHALL write all L bytes before the descriptor, so a non-empty pointer FIFO guarantees a complete frame.
REQ-015 bp SHALL be registered as (data FIFO count > 2578) OR (pointer FIFO full).
REQ-016 Header length H SHALL equal L+2 (12 bits, wraps); padded length P SHALL equal H rounded up to a multiple of 64; the cell count SHALL equal P/16.
REQ-017 Cell 0 byte 0 SHALL be {H[11:8], portmap}, byte 1 SHALL be H[7:0], and bytes 2..15 SHALL be frame bytes 0..13; later cells SHALL carry 16 frame bytes each.
REQ-018 Byte positions beyond L frame bytes SHALL be driven 8'h00.
REQ-019 FSM states: IDLE, LOAD, FILL, EMIT, WAIT_BP.
REQ-020 IDLE SHALL read the pointer FIFO when it is non-empty and i_cell_data_fifo_bp is low, then go to LOAD.
REQ-021 LOAD SHALL latch L, portmap, H and P, and preload header bytes.
REQ-022 FILL SHALL read one byte per cycle while the frame byte counter < L, assembling cell slots in order; pad slots SHALL consume no FIFO read.
REQ-023 EMIT SHALL assert i_cell_data_fifo_wr for exactly one cycle when 16 slots are filled; i_cell_first SHALL be set on cell 0 and i_cell_last on cell P/16-1.
REQ-024 After a non-last cell, the FSM SHALL go to WAIT_BP if i_cell_data_fifo_bp is high, otherwise to FILL; WAIT_BP SHALL hold with no FIFO reads until bp is low.
REQ-025 After the last cell, the FSM SHALL return to IDLE, and the next frame MAY start on the following cycle.
REQ-026 With bp low, consecutive cell writes SHALL be spaced exactly 16 cycles apart, and the first cell SHALL be written within 20 cycles of the pointer read.
REQ-027 L=0 SHALL still emit 4 cells (H=2) carrying header only.
REQ-028 Exactly L data-FIFO reads SHALL occur per frame.

Reset
REQ-029 rstn low SHALL flush both FIFOs, force state IDLE, clear counters, and drive bp, i_cell_data_fifo_wr, i_cell_first and i_cell_last to 0 and i_cell_data_fifo_dout to 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no further cell writes; the next frame after release SHALL be correct.

Structure
REQ-031 The shared package SHALL hold constants for cell bytes (16), pad granule (64), bp threshold (2578), header size (2), and the FSM state encoding.
REQ-032 The byte-to-cell packer (slot index, 128-bit shift/assemble, zero pad) SHALL be one sub-module, switch_pre_pack.

Verification
REQ-033 L=60, portmap 4'h3: expect 4 cells; cell0[127:112]=16'h033E; last cell ends with 2 zero bytes; first and last flags set on cells 0 and 3.
REQ-034 L=62 (H=64): expect 4 cells with no pad bytes; L=63: expect 8 cells with 63 zero pad bytes.
REQ-035 Two back-to-back frames of L=60 and L=1514: expect 4 then 96 cells with correct flags and no gap beyond 1 idle cycle.
REQ-036 i_cell_data_fifo_bp raised after cell 1 for 50 cycles: expect no writes or reads during the stall, then resume with byte order intact.
REQ-037 Fill the data FIFO past 2578 bytes: expect bp=1 one cycle later; 32 queued descriptors: expect bp=1.
REQ-038 rstn pulsed during cell 2 of L=1000: expect outputs 0, FIFOs empty, and a subsequent L=60 frame emitted correctly.

Source files
------------

// File: rtl/switch_pre_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : switch_pre_pkg
//  Purpose : Shared constants, FSM state encoding and the cell-count helper
//            for the switch_pre frame-to-cell converter.
//  Rev     : 1.0  initial release
// ============================================================================
package switch_pre_pkg;

    localparam int C_CELL_BYTES   = 16;    // bytes per 128-bit cell
    localparam int C_PAD_GRANULE  = 64;    // header+frame padded to this size
    localparam int C_BP_THRESHOLD = 2578;  // data FIFO fill level for bp
    localparam int C_HDR_BYTES    = 2;     // {H[11:8],portmap}, H[7:0]
    localparam int C_DFIFO_DEPTH  = 4096;
    localparam int C_PFIFO_DEPTH  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FILL    = 3'd2,
        ST_EMIT    = 3'd3,
        ST_WAIT_BP = 3'd4
    } state_t;

    // Number of cells for header length h: h rounded up to the pad granule,
    // expressed in cells. Largest value is 256, hence 9 bits.
    function automatic logic [8:0] cell_count(input logic [11:0] h);
        return 9'((({1'b0, h} + 13'(C_PAD_GRANULE - 1)) / 13'(C_PAD_GRANULE))
                  * 13'(C_PAD_GRANULE / C_CELL_BYTES));
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_pre_pack.sv
`default_nettype none
// ============================================================================
//  Module  : switch_pre_pack
//  Purpose : Byte-to-cell packer. Tracks the slot index, accepts one slot
//            operation per cycle (FIFO byte or zero pad), absorbs the data
//            FIFO's one-cycle read latency and presents the assembled cell.
//  Ports   : hdr_ld_i/hdr_i  preload slots 0/1 and restart at slot 2
//            op_i/op_rd_i    issue a slot op; op_rd_i=1 means FIFO byte
//            byte_i          data FIFO output (valid the cycle after a read)
//            slot_o          index of the next slot to issue
//            cell_o          cell, including the byte landing this cycle
//  Rev     : 1.0  initial release
// ============================================================================
module switch_pre_pack
    import switch_pre_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         hdr_ld_i,
    input  logic [15:0]  hdr_i,
    input  logic         op_i,
    input  logic         op_rd_i,
    input  logic [7:0]   byte_i,
    output logic [3:0]   slot_o,
    output logic [127:0] cell_o
);

    logic [3:0] slot_q;
    logic       pend_q;       // a slot op was issued last cycle
    logic       pend_rd_q;    // ... and it was a FIFO read
    logic [3:0] pend_slot_q;  // ... targeting this slot
    logic [7:0] byte_q [0:C_CELL_BYTES-1];
    logic [7:0] w_land;

    assign w_land = pend_rd_q ? byte_i : 8'h00;
    assign slot_o = slot_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_q      <= '0;
            pend_q      <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_slot_q <= '0;
            for (int k = 0; k < C_CELL_BYTES; k++) byte_q[k] <= '0;
        end else begin
            pend_q      <= op_i;
            pend_rd_q   <= op_rd_i;
            pend_slot_q <= slot_q;
            if (hdr_ld_i) begin
                slot_q    <= 4'(C_HDR_BYTES);
                byte_q[0] <= hdr_i[15:8];
                byte_q[1] <= hdr_i[7:0];
            end else if (op_i) begin
                slot_q <= slot_q + 4'd1;   // wraps 15 -> 0 for the next cell
            end
            if (pend_q) byte_q[pend_slot_q] <= w_land;
        end
    end

    // The final slot lands in the same cycle the cell is emitted, so the
    // landing byte bypasses the slot register.
    generate
        for (genvar k = 0; k < C_CELL_BYTES; k++) begin : g_byte
            assign cell_o[127-8*k -: 8] = (pend_q && (pend_slot_q == 4'(k)))
                                          ? w_land : byte_q[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/switch_pre.sv
`default_nettype none
// ============================================================================
//  Module  : switch_pre
//  Purpose : Buffers frame bytes and descriptors, prepends a 2-byte header,
//            zero-pads to a 64-byte multiple and emits 128-bit cells.
//  Ports   : data_fifo_wr/din   upstream bytes (all bytes before descriptor)
//            ptr_fifo_wr/din    descriptor {portmap[3:0], length[11:0]}
//            bp                 registered upstream backpressure
//            i_cell_data_fifo_* cell write strobe, data, first/last flags,
//                               downstream almost-full input
//  Rev     : 1.0  initial release
// ============================================================================
module switch_pre
    import switch_pre_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         data_fifo_wr,
    input  logic [7:0]   data_fifo_din,
    input  logic         ptr_fifo_wr,
    input  logic [15:0]  ptr_fifo_din,
    output logic         bp,
    output logic         i_cell_data_fifo_wr,
    output logic [127:0] i_cell_data_fifo_dout,
    output logic         i_cell_first,
    output logic         i_cell_last,
    input  logic         i_cell_data_fifo_bp
);

    // ---------------- data FIFO (8 x 4096, registered read) ----------------
    logic [7:0]  dmem_q [0:C_DFIFO_DEPTH-1];
    logic [11:0] dwptr_q, drptr_q;
    logic [12:0] dcnt_q;
    logic [7:0]  ddout_q;
    logic        w_dwr, w_drd;

    assign w_dwr = data_fifo_wr && (dcnt_q != 13'(C_DFIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (w_dwr) dmem_q[dwptr_q] <= data_fifo_din;
        if (w_drd) ddout_q <= dmem_q[drptr_q];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dwptr_q <= '0;
            drptr_q <= '0;
            dcnt_q  <= '0;
        end else begin
            if (w_dwr) dwptr_q <= dwptr_q + 12'd1;
            if (w_drd) drptr_q <= drptr_q + 12'd1;
            dcnt_q <= dcnt_q + 13'(w_dwr) - 13'(w_drd);
        end
    end

    // --------------- pointer FIFO (16 x 32, registered read) ---------------
    logic [15:0] pmem_q [0:C_PFIFO_DEPTH-1];
    logic [4:0]  pwptr_q, prptr_q;
    logic [5:0]  pcnt_q;
    logic [15:0] pdout_q;
    logic        w_pwr, w_prd, w_pfull;

    assign w_pfull = (pcnt_q == 6'(C_PFIFO_DEPTH));
    assign w_pwr   = ptr_fifo_wr && !w_pfull;

    always_ff @(posedge clk) begin
        if (w_pwr) pmem_q[pwptr_q] <= ptr_fifo_din;
        if (w_prd) pdout_q <= pmem_q[prptr_q];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwptr_q <= '0;
            prptr_q <= '0;
            pcnt_q  <= '0;
        end else begin
            if (w_pwr) pwptr_q <= pwptr_q + 5'd1;
            if (w_prd) prptr_q <= prptr_q + 5'd1;
            pcnt_q <= pcnt_q + 6'(w_pwr) - 6'(w_prd);
        end
    end

    // ------------------------------- FSM -----------------------------------
    state_t      state_q, state_d;
    logic [11:0] len_q, len_d;
    logic [11:0] rd_cnt_q, rd_cnt_d;       // frame bytes already requested
    logic [8:0]  cell_q, cell_d;           // index of cell being assembled
    logic [8:0]  last_idx_q, last_idx_d;
    logic        w_hdr_ld, w_op, w_op_rd, w_emit;
    logic [11:0] w_len, w_hlen;
    logic [3:0]  w_slot;
    logic [127:0] w_cell;

    assign w_len  = pdout_q[11:0];
    assign w_hlen = w_len + 12'(C_HDR_BYTES);   // wraps at 12 bits

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_cnt_d   = rd_cnt_q;
        cell_d     = cell_q;
        last_idx_d = last_idx_q;
        w_prd      = 1'b0;
        w_hdr_ld   = 1'b0;
        w_op       = 1'b0;
        w_emit     = 1'b0;
        w_op_rd    = (rd_cnt_q < len_q);   // otherwise the slot is padding
        case (state_q)
            ST_IDLE: begin
                if ((pcnt_q != 6'd0) && !i_cell_data_fifo_bp) begin
                    w_prd   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                len_d      = w_len;
                last_idx_d = cell_count(w_hlen) - 9'd1;
                rd_cnt_d   = '0;
                cell_d     = '0;
                w_hdr_ld   = 1'b1;
                state_d    = ST_FILL;
            end
            ST_FILL: begin
                w_op = 1'b1;
                if (w_slot == 4'd15) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                w_emit = 1'b1;
                cell_d = cell_q + 9'd1;
                if (cell_q == last_idx_q) begin
                    state_d = ST_IDLE;
                end else if (i_cell_data_fifo_bp) begin
                    state_d = ST_WAIT_BP;
                end else begin
                    // Issue slot 0 of the next cell here so cells stay
                    // exactly 16 cycles apart.
                    w_op    = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_WAIT_BP: begin
                if (!i_cell_data_fifo_bp) state_d = ST_FILL;
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_op && w_op_rd) rd_cnt_d = rd_cnt_q + 12'd1;
    end

    assign w_drd = w_op && w_op_rd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            cell_q     <= '0;
            last_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            cell_q     <= cell_d;
            last_idx_q <= last_idx_d;
        end
    end

    switch_pre_pack u_pack (
        .clk      (clk),
        .rstn     (rstn),
        .hdr_ld_i (w_hdr_ld),
        .hdr_i    ({w_hlen[11:8], pdout_q[15:12], w_hlen[7:0]}),
        .op_i     (w_op),
        .op_rd_i  (w_op_rd),
        .byte_i   (ddout_q),
        .slot_o   (w_slot),
        .cell_o   (w_cell)
    );

    // --------------------------- output registers --------------------------
    logic         wr_q, first_q, last_q, bp_q;
    logic [127:0] dout_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            bp_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            wr_q    <= w_emit;
            first_q <= w_emit && (cell_q == 9'd0);
            last_q  <= w_emit && (cell_q == last_idx_q);
            bp_q    <= (dcnt_q > 13'(C_BP_THRESHOLD)) || w_pfull;
            if (w_emit) dout_q <= w_cell;
        end
    end

    assign bp                    = bp_q;
    assign i_cell_data_fifo_wr   = wr_q;
    assign i_cell_first          = first_q;
    assign i_cell_last           = last_q;
    assign i_cell_data_fifo_dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_pre.sv
`default_nettype none
// ============================================================================
//  Module  : tb_switch_pre
//  Purpose : Directed self-checking bench for switch_pre. A small reference
//            model turns each frame into its expected cells; a monitor
//            compares every cell write against that queue.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_switch_pre;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         data_fifo_wr = 1'b0;
    logic [7:0]   data_fifo_din = '0;
    logic         ptr_fifo_wr = 1'b0;
    logic [15:0]  ptr_fifo_din = '0;
    logic         i_cell_data_fifo_bp = 1'b0;
    logic         bp;
    logic         i_cell_data_fifo_wr;
    logic [127:0] i_cell_data_fifo_dout;
    logic         i_cell_first;
    logic         i_cell_last;

    always #5 clk = ~clk;

    switch_pre u_dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .data_fifo_wr          (data_fifo_wr),
        .data_fifo_din         (data_fifo_din),
        .ptr_fifo_wr           (ptr_fifo_wr),
        .ptr_fifo_din          (ptr_fifo_din),
        .bp                    (bp),
        .i_cell_data_fifo_wr   (i_cell_data_fifo_wr),
        .i_cell_data_fifo_dout (i_cell_data_fifo_dout),
        .i_cell_first          (i_cell_first),
        .i_cell_last           (i_cell_last),
        .i_cell_data_fifo_bp   (i_cell_data_fifo_bp)
    );

    typedef struct {
        logic [127:0] data;
        logic         first;
        logic         last;
    } cell_t;

    cell_t        exp_q[$];
    int           wr_times[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           wr_cnt = 0;
    int           n_spurious = 0;
    int           cyc = 0;
    logic [127:0] first_cell = '0;
    logic [127:0] last_cell = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        cell_t e;
        if (rstn && i_cell_data_fifo_wr) begin
            wr_cnt++;
            wr_times.push_back(cyc);
            last_cell = i_cell_data_fifo_dout;
            if (i_cell_first) first_cell = i_cell_data_fifo_dout;
            if (exp_q.size() == 0) begin
                n_spurious++;
            end else begin
                e = exp_q.pop_front();
                check("cell_data",  i_cell_data_fifo_dout, e.data);
                check("cell_first", 128'(i_cell_first), 128'(e.first));
                check("cell_last",  128'(i_cell_last), 128'(e.last));
            end
        end
    end

    // Reference: header + frame bytes + zero pad, cut into 16-byte cells.
    function automatic void model_frame(input int len, input logic [3:0] pm, input logic [7:0] b[$]);
        logic [11:0] h;
        int          ncell;
        logic [7:0]  s[$];
        cell_t       c;
        h     = 12'(len + 2);
        ncell = ((int'(h) + 63) / 64) * 4;
        s.push_back({h[11:8], pm});
        s.push_back(h[7:0]);
        foreach (b[i]) s.push_back(b[i]);
        while (s.size() < ncell * 16) s.push_back(8'h00);
        for (int k = 0; k < ncell; k++) begin
            c.data = '0;
            for (int j = 0; j < 16; j++) c.data[127-8*j -: 8] = s[16*k+j];
            c.first = (k == 0);
            c.last  = (k == ncell - 1);
            exp_q.push_back(c);
        end
    endfunction

    task automatic send_frame(input int len, input logic [3:0] pm, input logic [7:0] seed);
        logic [7:0] b[$];
        logic [7:0] v;
        for (int i = 0; i < len; i++) begin
            v = seed + 8'(i * 7);
            b.push_back(v);
            data_fifo_wr  = 1'b1;
            data_fifo_din = v;
            @(negedge clk);
        end
        data_fifo_wr = 1'b0;
        model_frame(len, pm, b);
        ptr_fifo_din = {pm, 12'(len)};
        ptr_fifo_wr  = 1'b1;
        @(negedge clk);
        ptr_fifo_wr = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check({tag, "_drain"}, 128'(exp_q.size()), 128'(0));
        check({tag, "_spurious"}, 128'(n_spurious), 128'(0));
        exp_q.delete();
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bp"},    128'(bp), 128'(0));
        check({tag, "_wr"},    128'(i_cell_data_fifo_wr), 128'(0));
        check({tag, "_first"}, 128'(i_cell_first), 128'(0));
        check({tag, "_last"},  128'(i_cell_last), 128'(0));
        check({tag, "_dout"},  i_cell_data_fifo_dout, 128'(0));
    endtask

    initial begin
        int         base, t0, lat, n16, n17, d, w;
        logic [7:0] none[$];

        // ---- reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;
        @(negedge clk);

        // ---- L=60, portmap 3
        base = wr_cnt;
        send_frame(60, 4'h3, 8'h10);
        wait_drain("l60", 400);
        check("l60_cells", 128'(wr_cnt - base), 128'(4));
        check("l60_hdr",   128'(first_cell[127:112]), 128'(16'h033E));
        check("l60_tail",  128'(last_cell[15:0]), 128'(0));

        // ---- L=62: exactly 64 bytes, no padding
        base = wr_cnt;
        send_frame(62, 4'h5, 8'h01);
        wait_drain("l62", 400);
        check("l62_cells",    128'(wr_cnt - base), 128'(4));
        check("l62_lastbyte", 128'(last_cell[7:0]), 128'(8'hAC));

        // ---- L=63: spills into a second 64-byte block
        base = wr_cnt;
        send_frame(63, 4'hA, 8'h22);
        wait_drain("l63", 400);
        check("l63_cells", 128'(wr_cnt - base), 128'(8));
        check("l63_tail",  last_cell, 128'(0));

        // ---- back-to-back L=60 then L=1514, released together
        i_cell_data_fifo_bp = 1'b1;
        send_frame(60, 4'h1, 8'h40);
        send_frame(1514, 4'hF, 8'h80);
        wr_times.delete();
        t0 = cyc;
        i_cell_data_fifo_bp = 1'b0;
        wait_drain("b2b", 3000);
        check("b2b_cells", 128'(wr_times.size()), 128'(100));
        lat = (wr_times.size() > 0) ? (wr_times[0] - t0) : 9999;
        check("b2b_first_latency_ok", 128'(lat <= 20), 128'(1));
        n16 = 0;
        n17 = 0;
        for (int i = 1; i < wr_times.size(); i++) begin
            d = wr_times[i] - wr_times[i-1];
            if (d == 16) n16++;
            else if (d == 17) n17++;
        end
        check("b2b_gap16", 128'(n16), 128'(98));
        check("b2b_gap17", 128'(n17), 128'(1));

        // ---- downstream stall raised after cell 1
        base = wr_cnt;
        send_frame(200, 4'h6, 8'h33);
        wait_writes(base + 2, 300);
        check("stall_pre", 128'(wr_cnt - base), 128'(2));
        i_cell_data_fifo_bp = 1'b1;
        repeat (20) @(negedge clk);
        w = wr_cnt;
        repeat (30) @(negedge clk);
        check("stall_quiet", 128'(wr_cnt - w), 128'(0));
        i_cell_data_fifo_bp = 1'b0;
        wait_drain("stall", 600);
        check("stall_cells", 128'(wr_cnt - base), 128'(16));

        // ---- pointer FIFO full (32 header-only L=0 frames)
        i_cell_data_fifo_bp = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                repeat (2) @(negedge clk);
                check("bp_ptr31", 128'(bp), 128'(0));
            end
            model_frame(0, 4'(i), none);
            ptr_fifo_din = {4'(i), 12'd0};
            ptr_fifo_wr  = 1'b1;
            @(negedge clk);
            ptr_fifo_wr = 1'b0;
        end
        @(negedge clk);
        check("bp_ptr32", 128'(bp), 128'(1));
        base = wr_cnt;
        i_cell_data_fifo_bp = 1'b0;
        wait_drain("l0", 6000);
        check("l0_cells", 128'(wr_cnt - base), 128'(128));
        check("bp_ptr_drained", 128'(bp), 128'(0));

        // ---- data FIFO threshold
        i_cell_data_fifo_bp = 1'b1;
        for (int i = 0; i < 2578; i++) begin
            data_fifo_wr  = 1'b1;
            data_fifo_din = 8'(i);
            @(negedge clk);
        end
        data_fifo_wr = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_at_2578", 128'(bp), 128'(0));
        data_fifo_wr = 1'b1;
        @(negedge clk);
        data_fifo_wr = 1'b0;
        check("bp_same_cycle", 128'(bp), 128'(0));
        @(negedge clk);
        check("bp_over", 128'(bp), 128'(1));
        rstn = 1'b0;
        @(negedge clk);
        check("bp_flush", 128'(bp), 128'(0));
        rstn = 1'b1;
        i_cell_data_fifo_bp = 1'b0;
        @(negedge clk);

        // ---- reset during cell 2 of L=1000, then a clean L=60
        base = wr_cnt;
        send_frame(1000, 4'h9, 8'h5A);
        wait_writes(base + 2, 300);
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        rstn = 1'b1;
        base = wr_cnt;
        repeat (40) @(negedge clk);
        check("midrst_quiet", 128'(wr_cnt - base), 128'(0));
        send_frame(60, 4'h3, 8'h10);
        wait_drain("post", 400);
        check("post_cells", 128'(wr_cnt - base), 128'(4));
        check("post_hdr",   128'(first_cell[127:112]), 128'(16'h033E));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
